// File: rtl/decimal_convert_arbiter_if.sv
// Request/result bundle between the requesters and the shared decimal conversion engine.
interface decimal_convert_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_value;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic                 done;
  logic [ID_W-1:0]      done_id;
  logic [3:0]           hundreds;
  logic [3:0]           tens;
  logic [3:0]           ones;

  modport master (
    output req, req_value,
    input  ack, busy, done, done_id, hundreds, tens, ones
  );

  modport slave (
    input  req, req_value,
    output ack, busy, done, done_id, hundreds, tens, ones
  );
endinterface

// File: rtl/decimal_convert_arbiter.sv
// Round-robin shared binary-to-BCD engine: 8-bit value -> hundreds/tens/ones by
// repeated subtraction, result returned with a one-cycle done tagged by requester ID.
module decimal_convert_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic clk,
  input  logic rst_n,
  decimal_convert_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SUB100, SUB10, DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         rem_q, rem_d;
  logic [3:0]         hund_q, hund_d;
  logic [3:0]         tcnt_q, tcnt_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [3:0]         hundreds_q, hundreds_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;

  logic               found;
  logic [ID_W-1:0]    gnt;
  logic [ID_W-1:0]    cand;

  // Search starts one past the last grant and wraps, so the last winner ranks lowest.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(last_grant_q) + i) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    hund_d       = hund_q;
    tcnt_d       = tcnt_q;
    cur_id_d     = cur_id_q;
    last_grant_d = last_grant_q;
    ack_d        = '0;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    hundreds_d   = hundreds_q;
    tens_d       = tens_q;
    ones_d       = ones_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = SUB100;
          rem_d        = bus.req_value[8*gnt +: 8];
          hund_d       = '0;
          tcnt_d       = '0;
          cur_id_d     = gnt;
          last_grant_d = gnt;
          ack_d[gnt]   = 1'b1;
        end
      end
      SUB100: begin
        if (rem_q >= 8'd100) begin
          rem_d  = rem_q - 8'd100;
          hund_d = hund_q + 4'd1;
        end else begin
          state_d = SUB10;
        end
      end
      SUB10: begin
        if (rem_q >= 8'd10) begin
          rem_d  = rem_q - 8'd10;
          tcnt_d = tcnt_q + 4'd1;
        end else begin
          state_d    = DONE;
          done_d     = 1'b1;
          done_id_d  = cur_id_q;
          hundreds_d = hund_q;
          tens_d     = tcnt_q;
          ones_d     = rem_q[3:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      hund_q       <= '0;
      tcnt_q       <= '0;
      cur_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      ack_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= '0;
      hundreds_q   <= '0;
      tens_q       <= '0;
      ones_q       <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      hund_q       <= hund_d;
      tcnt_q       <= tcnt_d;
      cur_id_q     <= cur_id_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      hundreds_q   <= hundreds_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.done_id  = done_id_q;
  assign bus.hundreds = hundreds_q;
  assign bus.tens     = tens_q;
  assign bus.ones     = ones_q;

endmodule

// File: tb/tb_decimal_convert_arbiter.sv
// Scoreboard bench: a negedge monitor models arbitration/latency, pushes expected results
// on each grant and pops/compares on each done pulse.
module tb_decimal_convert_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct {
    int id;
    int h;
    int t;
    int o;
    int due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;

  exp_t sb[$];
  int   grant_log[$];

  decimal_convert_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  decimal_convert_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  // Monitor / model state
  logic [NUM_REQ-1:0]   snap_req;
  logic [8*NUM_REQ-1:0] snap_val;
  logic [NUM_REQ-1:0]   exp_ack;
  int  rr_last = NUM_REQ - 1;
  int  busy_until = -1;
  bit  prev_idle = 1'b0;
  bit  prev_done = 1'b0;
  bit  mfound;
  int  mg, mc, mv;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      rr_last    = NUM_REQ - 1;
      busy_until = -1;
      prev_idle  = 1'b0;
      prev_done  = 1'b0;
    end else begin
      exp_ack = '0;
      mfound  = 1'b0;
      mg      = 0;
      if (prev_idle && (snap_req != '0)) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          mc = (rr_last + k) % NUM_REQ;
          if (!mfound && snap_req[mc]) begin
            mfound = 1'b1;
            mg     = mc;
          end
        end
        exp_ack[mg] = 1'b1;
      end
      checks++;
      if (bus.ack !== exp_ack) begin
        errors++;
        $display("FAIL ack cycle %0d: got %b expected %b", cnt, bus.ack, exp_ack);
      end
      if (mfound) begin
        rr_last = mg;
        mv      = int'(snap_val[mg*8 +: 8]);
        e.id  = mg;
        e.h   = mv / 100;
        e.t   = (mv / 10) % 10;
        e.o   = mv % 10;
        e.due = cnt + e.h + e.t + 2;
        busy_until = e.due;
        sb.push_back(e);
        grant_log.push_back(mg);
      end
      checks++;
      if (bus.busy !== (cnt <= busy_until)) begin
        errors++;
        $display("FAIL busy cycle %0d: got %b expected %b", cnt, bus.busy, (cnt <= busy_until));
      end
      if (bus.done) begin
        done_count++;
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width cycle %0d: done high two cycles in a row", cnt);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cycle %0d: id %0d digits %0d/%0d/%0d", cnt,
                   bus.done_id, bus.hundreds, bus.tens, bus.ones);
        end else begin
          e = sb.pop_front();
          if (int'(bus.done_id) != e.id || int'(bus.hundreds) != e.h ||
              int'(bus.tens) != e.t || int'(bus.ones) != e.o) begin
            errors++;
            $display("FAIL result cycle %0d: got id %0d %0d/%0d/%0d expected id %0d %0d/%0d/%0d",
                     cnt, bus.done_id, bus.hundreds, bus.tens, bus.ones, e.id, e.h, e.t, e.o);
          end
          checks++;
          if (cnt != e.due) begin
            errors++;
            $display("FAIL latency id %0d: done at cycle %0d expected %0d", e.id, cnt, e.due);
          end
        end
      end
      prev_done = bus.done;
      prev_idle = (cnt > busy_until);
    end
    snap_req = bus.req;
    snap_val = bus.req_value;
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({bus.ack, bus.busy, bus.done, bus.done_id, bus.hundreds, bus.tens, bus.ones} !== '0) begin
      errors++;
      $display("FAIL %s: ack %b busy %b done %b id %0d digits %0d/%0d/%0d expected all zero", tag,
               bus.ack, bus.busy, bus.done, bus.done_id, bus.hundreds, bus.tens, bus.ones);
    end
  endtask

  task automatic drive(input int id, input logic [7:0] v);
    @(posedge clk); #2;
    bus.req[id] = 1'b1;
    bus.req_value[id*8 +: 8] = v;
  endtask

  task automatic wait_ack(input int id);
    bit got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.ack[id]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout requester %0d: got none expected ack", id);
    end
    @(posedge clk); #2;
    bus.req[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, input int eh, input int et, input int eo);
    bit got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.done && int'(bus.done_id) == id) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout requester %0d: got none expected done", id);
    end else if (int'(bus.hundreds) != eh || int'(bus.tens) != et || int'(bus.ones) != eo) begin
      errors++;
      $display("FAIL digits requester %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", id,
               bus.hundreds, bus.tens, bus.ones, eh, et, eo);
    end
  endtask

  task automatic conv(input int id, input logic [7:0] v, input int eh, input int et, input int eo);
    drive(id, v);
    wait_ack(id);
    wait_done(id, eh, et, eo);
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy && sb.size() == 0 && bus.req == '0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy %b pending %0d expected idle", bus.busy, sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  int dc0;
  bit got_rr;

  initial begin
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_value = '0;
    #12;
    check_reset_outputs("reset_state");
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed conversions with hand-computed digits
    conv(0, 8'd0, 0, 0, 0);
    conv(1, 8'd99, 0, 9, 9);
    conv(1, 8'd255, 2, 5, 5);
    conv(3, 8'd128, 1, 2, 8);
    wait_idle();

    // All four held: strict rotation starting after requester 3
    grant_log.delete();
    @(posedge clk); #2;
    bus.req_value = {8'd40, 8'd30, 8'd20, 8'd10};
    bus.req = 4'b1111;
    got_rr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 8) begin
        got_rr = 1'b1;
        break;
      end
    end
    @(posedge clk); #2;
    bus.req = '0;
    checks++;
    if (!got_rr || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 2 ||
        grant_log[3] != 3 || grant_log[4] != 0 || grant_log[5] != 1 ||
        grant_log[6] != 2 || grant_log[7] != 3) begin
      errors++;
      $display("FAIL rr_order: got %p expected 0 1 2 3 0 1 2 3", grant_log);
    end
    wait_idle();

    // Request raised while busy; value changes before ack count, after ack do not
    drive(0, 8'd200);
    wait_ack(0);
    drive(2, 8'd11);
    @(posedge clk); #2;
    bus.req_value[2*8 +: 8] = 8'd57;
    wait_ack(2);
    bus.req_value[2*8 +: 8] = 8'd99;
    wait_done(2, 0, 5, 7);
    wait_idle();

    // Reset in the middle of SUB10 while converting 87
    drive(0, 8'd87);
    wait_ack(0);
    @(posedge clk); #2;
    dc0 = done_count;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_op");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (done_count != dc0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d dones expected 0", done_count - dc0);
    end
    grant_log.delete();
    @(posedge clk); #2;
    bus.req_value[3*8 +: 8] = 8'd5;
    bus.req_value[0*8 +: 8] = 8'd6;
    bus.req[3] = 1'b1;
    bus.req[0] = 1'b1;
    wait_ack(0);
    checks++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin
      errors++;
      $display("FAIL post_reset_priority: got %p expected first grant 0", grant_log);
    end
    wait_ack(3);
    wait_idle();

    // Exhaustive sweep from requester 1 at back-to-back throughput
    for (int v = 0; v < 256; v++) begin
      drive(1, 8'(v));
      wait_ack(1);
      wait_done(1, v / 100, (v / 10) % 10, v % 10);
    end
    wait_idle();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decimal_convert_arbiter.md
Name: decimal_convert_arbiter

Overview:
- Shares one sequential binary-to-decimal conversion engine among NUM_REQ requesters, e.g. keypad entry, score counter and timer feeding the 7-segment display driver.
- Arbitrates requests round-robin and converts the granted 8-bit value to hundreds/tens/ones digits by iterative subtraction.
- Returns the digits with a done pulse tagged by requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..4).
- ID_W, 2, width of the requester ID; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request level.
- req_value  input  8*NUM_REQ  packed values; requester i uses bits [8i+7:8i].
- ack  output  NUM_REQ  one-cycle grant/accept pulse, one-hot.
- busy  output  1  high whenever the engine is not IDLE.
- done  output  1  one-cycle result-valid pulse.
- done_id  output  ID_W  index of the requester whose result is presented.
- hundreds  output  4  hundreds digit (0..2).
- tens  output  4  tens digit (0..9).
- ones  output  4  ones digit (0..9).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - ack=0, busy=0, done=0, done_id=0, hundreds=tens=ones=0.
  - Working remainder and digit counters = 0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has highest priority first.
- Reset mid-operation aborts the conversion: no done, no partial result, pointer restored.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SUB100, SUB10, DONE.
- IDLE:
  - If req != 0 at edge E0: grant the first asserted requester searching (last_grant+1) mod NUM_REQ upward with wrap.
  - At E0: latch its value into rem; clear the digit counters; set last_grant; set ack[g]=1 for exactly the cycle after E0; go to SUB100.
  - If req = 0: stay in IDLE.
- SUB100: if rem>=100, rem<=rem-100 and hund<=hund+1, stay; else go to SUB10.
- SUB10: if rem>=10, rem<=rem-10 and tens<=tens+1, stay; else ones<=rem[3:0], go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - hundreds/tens/ones/done_id are updated on entry to DONE.
  - Next edge: go to IDLE.
- Output hold: digit and done_id outputs hold their value until the next entry to DONE.
- Latency: with h=value/100 and t=(value%100)/10, done is high in the cycle after edge E0+h+t+2.
  - Value 0: 3rd cycle after E0.
  - Value 255: cycle after E0+9.
- Throughput: the earliest next acceptance is edge E0+h+t+4, since DONE always returns to IDLE first.
- Requester handshake:
  - Requester holds req and value stable until it sees ack.
  - req_value is sampled only at the accept edge; later changes do not affect the conversion.
  - A req still high after ack is treated as a new request and re-arbitrated in IDLE.
  - Requests arriving while busy wait; they are never dropped and never acked twice per accept.
- Simultaneous requests: exactly one grant per accept; strict round-robin order guarantees each pending requester is served within NUM_REQ conversions.
- Arithmetic:
  - rem is 8 bits and never underflows, because it is compared before subtracting.
  - hund is at most 2 and tens at most 9; all values 0..255 are legal.
- Bits of req/req_value at or above NUM_REQ are ignored.

Test Plan:
- Reset, then req=0001 with value 0 → ack=0001 for one cycle; done 3 cycles after accept edge; digits 0/0/0; done_id=0; busy high from accept until return to IDLE.
- req[1] with value 99 → done after E0+11; digits 0/9/9; done_id=1. Then req[1] with value 255 → done after E0+9; digits 2/5/5.
- req=1111 held continuously with values 10,20,30,40 → grant order 0,1,2,3,0,…; digits 0/1/0, 0/2/0, 0/3/0, 0/4/0 with matching done_id; no requester starved.
- req[2] raised while busy converting for req[0] → req[2] acked only after DONE→IDLE; changing its value before ack changes the converted value, changing it after ack does not.
- Assert rst_n=0 mid-SUB10 during conversion of 87 → outputs go to 0 immediately; no done. After release, req=1000 and req=0001 together → requester 0 is granted first.
- Exhaustive sweep of values 0..255 from a single requester → digits equal value/100, (value/10)%10, value%10; latency equals h+t+2 per the formula.
